// File: rtl/fetch_redirect_queue.sv
// Fetch unit: issues instruction-memory reads under a credit scheme, buffers responses, flushes on redirect.
// Optional same-cycle response bypass to the head when the queue is empty: define FQ_BYPASS_EN.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

// state      | meaning
// RESET_WAIT | one idle cycle after reset; late responses are ignored
// FETCH      | issuing sequential requests while credit is available
// HOLD       | queue plus in-flight request fill the queue; waiting for a dequeue
// REDIRECT   | queue flushed, first request at the redirect target issues here
module fetch_redirect_queue #(
  parameter int                    DEPTH    = 4,
  parameter logic [`PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                  fq_i_clk,
  input  logic                  fq_i_rst_n,
  output logic                  fq_o_imem_req,
  output logic [`PC_WIDTH-1:0]  fq_o_imem_addr,
  input  logic                  fq_i_imem_valid,
  input  logic [31:0]           fq_i_imem_instr,
  input  logic                  fq_i_change_pc,
  input  logic [`PC_WIDTH-1:0]  fq_i_alu_pc,
  input  logic                  fq_i_deq,
  output logic                  fq_o_ce,
  output logic [31:0]           fq_o_instr,
  output logic [`PC_WIDTH-1:0]  fq_o_pc,
  output logic                  fq_o_full,
  output logic                  fq_o_empty
);

  localparam int PCW = `PC_WIDTH;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  localparam logic [1:0] RESET_WAIT = 2'd0;
  localparam logic [1:0] FETCH      = 2'd1;
  localparam logic [1:0] HOLD       = 2'd2;
  localparam logic [1:0] REDIRECT   = 2'd3;

  logic [1:0]     state, state_next;
  logic [PCW-1:0] fetch_pc;
  logic [PCW-1:0] inflight_pc;
  logic           inflight;
  logic [AW:0]    count;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [31:0]    mem_instr [DEPTH];
  logic [PCW-1:0] mem_pc    [DEPTH];

  logic           credit;
  logic           issue;
  logic           push;
  logic           store;
  logic           deq_fire;
  logic           deq_mem;
  logic           head_valid;
  logic [31:0]    head_instr;
  logic [PCW-1:0] head_pc;
  logic [AW+1:0]  occupancy;

  // Memory latency is exactly one cycle, so at most one request is ever outstanding.
  assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign credit    = occupancy < DEPTH_W;
  assign issue     = !fq_i_change_pc && credit && ((state == FETCH) || (state == REDIRECT));

  // Only a response that matches an outstanding request is accepted; this drops
  // stale data after a redirect or reset without extra bookkeeping.
  assign push      = fq_i_imem_valid && inflight && !fq_i_change_pc;

`ifdef FQ_BYPASS_EN
  logic bypass;
  assign bypass     = push && (count == '0);
  assign head_valid = (count != '0) || bypass;
  assign head_instr = bypass ? fq_i_imem_instr : mem_instr[rd_ptr];
  assign head_pc    = bypass ? inflight_pc : mem_pc[rd_ptr];
  assign deq_fire   = fq_i_deq && head_valid && !fq_i_change_pc;
  assign store      = push && !(bypass && deq_fire);
  assign deq_mem    = deq_fire && !bypass;
`else
  assign head_valid = (count != '0);
  assign head_instr = mem_instr[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];
  assign deq_fire   = fq_i_deq && head_valid && !fq_i_change_pc;
  assign store      = push;
  assign deq_mem    = deq_fire;
`endif

  assign fq_o_imem_req  = issue;
  assign fq_o_imem_addr = issue ? fetch_pc : '0;
  assign fq_o_ce        = head_valid;
  assign fq_o_instr     = head_valid ? head_instr : '0;
  assign fq_o_pc        = head_valid ? head_pc : '0;
  assign fq_o_full      = (count == DEPTH_W[AW:0]);
  assign fq_o_empty     = (count == '0);

  always_comb begin
    state_next = state;
    if (fq_i_change_pc) begin
      state_next = REDIRECT;
    end else begin
      case (state)
        RESET_WAIT: state_next = FETCH;
        FETCH:      if (!credit) state_next = HOLD;
        HOLD:       if (credit) state_next = FETCH;
        REDIRECT:   state_next = FETCH;
        default:    state_next = RESET_WAIT;
      endcase
    end
  end

  always_ff @(posedge fq_i_clk or negedge fq_i_rst_n) begin
    if (!fq_i_rst_n) begin
      state       <= RESET_WAIT;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_next;
      if (fq_i_change_pc) begin
        fetch_pc <= fq_i_alu_pc;
        inflight <= 1'b0;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          fetch_pc    <= fetch_pc + PCW'(4);
          inflight_pc <= fetch_pc;
        end
        if (store)   wr_ptr <= wr_ptr + AW'(1);
        if (deq_mem) rd_ptr <= rd_ptr + AW'(1);
        if (store && !deq_mem)      count <= count + (AW+1)'(1);
        else if (!store && deq_mem) count <= count - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge fq_i_clk) begin
    if (store) begin
      mem_instr[wr_ptr] <= fq_i_imem_instr;
      mem_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_queue.sv
// Directed bench for fetch_redirect_queue: a one-cycle memory returns ~addr as the instruction word.
// Latency expectations follow FQ_BYPASS_EN when it is defined.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module tb_fetch_redirect_queue;
  localparam int PCW = `PC_WIDTH;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_valid;
  logic [31:0]    imem_instr;
  logic           change_pc = 1'b0;
  logic [PCW-1:0] alu_pc = '0;
  logic           deq = 1'b0;
  logic           ce;
  logic [31:0]    instr;
  logic [PCW-1:0] pc;
  logic           full;
  logic           empty;

  logic           mem_valid = 1'b0;
  logic [31:0]    mem_instr = '0;
  logic           force_valid = 1'b0;
  logic [31:0]    force_instr = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic [PCW-1:0] req_log [$];

  always #5 clk = ~clk;

  fetch_redirect_queue #(.DEPTH(4), .RESET_PC('0)) dut (
    .fq_i_clk        (clk),
    .fq_i_rst_n      (rst_n),
    .fq_o_imem_req   (imem_req),
    .fq_o_imem_addr  (imem_addr),
    .fq_i_imem_valid (imem_valid),
    .fq_i_imem_instr (imem_instr),
    .fq_i_change_pc  (change_pc),
    .fq_i_alu_pc     (alu_pc),
    .fq_i_deq        (deq),
    .fq_o_ce         (ce),
    .fq_o_instr      (instr),
    .fq_o_pc         (pc),
    .fq_o_full       (full),
    .fq_o_empty      (empty)
  );

  // instruction memory model, one-cycle read latency
  always @(posedge clk) begin
    mem_valid <= imem_req;
    mem_instr <= ~imem_addr;
  end
  assign imem_valid = mem_valid | force_valid;
  assign imem_instr = force_valid ? force_instr : mem_instr;

  always @(negedge clk) if (rst_n && imem_req) req_log.push_back(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    n_cmp++; if (imem_addr !== '0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL rst_ce: got %0b want 0", ce); end
    n_cmp++; if (instr !== '0) begin n_err++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_cmp++; if (pc !== '0) begin n_err++; $display("FAIL rst_pc: got %h want 0", pc); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %0b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %0b want 0", full); end
    // release; a stray response in the first cycle must be dropped
    req_log.delete();
    rst_n = 1'b1;
    force_valid = 1'b1;
    force_instr = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rel_c0_req: got %0b want 0", imem_req); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL rel_c0_ce: got %0b want 0", ce); end
    tick();
    force_valid = 1'b0;
    #1;
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL rel_stray_ce: got %0b want 0", ce); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rel_c1_req: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rel_c1_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_fill();
    logic [PCW-1:0] exp_addr;
    repeat (7) tick();
    n_cmp++; if (req_log.size() !== 4) begin n_err++; $display("FAIL fill_nreq: got %0d want 4", req_log.size()); end
    for (int i = 0; i < 4 && i < req_log.size(); i++) begin
      exp_addr = PCW'(4 * i);
      n_cmp++; if (req_log[i] !== exp_addr) begin n_err++; $display("FAIL fill_addr%0d: got %h want %h", i, req_log[i], exp_addr); end
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %0b want 1", full); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty: got %0b want 0", empty); end
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL fill_head_pc: got %h want 0", pc); end
    n_cmp++; if (instr !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL fill_head_instr: got %h want ffffffff", instr); end
  endtask

  task automatic test_deq_one();
    req_log.delete();
    deq = 1'b1;
    tick();
    deq = 1'b0;
    #1;
    n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL deq_head_pc: got %h want 4", pc); end
    n_cmp++; if (instr !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL deq_head_instr: got %h want fffffffb", instr); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL deq_full: got %0b want 0", full); end
    repeat (4) tick();
    n_cmp++; if (req_log.size() !== 1) begin n_err++; $display("FAIL deq_nreq: got %0d want 1", req_log.size()); end
    if (req_log.size() > 0) begin
      n_cmp++; if (req_log[0] !== 32'h10) begin n_err++; $display("FAIL deq_req_addr: got %h want 10", req_log[0]); end
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL deq_refull: got %0b want 1", full); end
  endtask

  task automatic test_back_to_back_stream();
    logic [PCW-1:0] exp_pc;
    int n_seen;
    exp_pc = 32'h4;
    n_seen = 0;
    deq = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ce === 1'b1) begin
        n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL stream_pc%0d: got %h want %h", i, pc, exp_pc); end
        n_cmp++; if (instr !== ~exp_pc) begin n_err++; $display("FAIL stream_instr%0d: got %h want %h", i, instr, ~exp_pc); end
        exp_pc = exp_pc + 32'h4;
        n_seen++;
      end
      tick();
    end
    n_cmp++; if (n_seen !== 12) begin n_err++; $display("FAIL stream_count: got %0d want 12", n_seen); end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 8 && imem_valid !== 1'b1; i++) tick();
    n_cmp++; if (imem_valid !== 1'b1) begin n_err++; $display("FAIL redir_resp_present: got %0b want 1", imem_valid); end
    change_pc = 1'b1;
    alu_pc = 32'h100;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_n_req: got %0b want 0", imem_req); end
    tick();
    change_pc = 1'b0;
    deq = 1'b0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL redir_n1_empty: got %0b want 1", empty); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL redir_n1_ce: got %0b want 0", ce); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL redir_n1_req: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_n1_addr: got %h want 100", imem_addr); end
    tick();
`ifdef FQ_BYPASS_EN
    n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL redir_n2_ce: got %0b want 1", ce); end
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL redir_n2_pc: got %h want 100", pc); end
`else
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL redir_n2_ce: got %0b want 0", ce); end
`endif
    tick();
    n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL redir_n3_ce: got %0b want 1", ce); end
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL redir_n3_pc: got %h want 100", pc); end
    n_cmp++; if (instr !== 32'hFFFF_FEFF) begin n_err++; $display("FAIL redir_n3_instr: got %h want fffffeff", instr); end
  endtask

  task automatic test_back_to_back_redirect();
    int n_stale;
    req_log.delete();
    change_pc = 1'b1;
    alu_pc = 32'h200;
    tick();
    alu_pc = 32'h300;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL b2b_second_req: got %0b want 0", imem_req); end
    tick();
    change_pc = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL b2b_req: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h300) begin n_err++; $display("FAIL b2b_addr: got %h want 300", imem_addr); end
    repeat (3) tick();
    n_stale = 0;
    foreach (req_log[i]) if (req_log[i] === 32'h200) n_stale++;
    n_cmp++; if (n_stale !== 0) begin n_err++; $display("FAIL b2b_stale_req: got %0d want 0", n_stale); end
    if (req_log.size() > 0) begin
      n_cmp++; if (req_log[0] !== 32'h300) begin n_err++; $display("FAIL b2b_first_req: got %h want 300", req_log[0]); end
    end
    n_cmp++; if (pc !== 32'h300) begin n_err++; $display("FAIL b2b_head_pc: got %h want 300", pc); end
  endtask

  task automatic test_wrap();
    change_pc = 1'b1;
    alu_pc = 32'hFFFF_FFFC;
    tick();
    change_pc = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first_addr: got %h want fffffffc", imem_addr); end
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    tick();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_head_pc: got %h want fffffffc", pc); end
    n_cmp++; if (instr !== 32'h3) begin n_err++; $display("FAIL wrap_head_instr: got %h want 3", instr); end
  endtask

  task automatic test_mid_reset();
    change_pc = 1'b1;
    alu_pc = 32'h400;
    tick();
    change_pc = 1'b0;
    repeat (4) tick();
    n_cmp++; if (ce !== 1'b1) begin n_err++; $display("FAIL mrst_pre_ce: got %0b want 1", ce); end
    n_cmp++; if (pc !== 32'h400) begin n_err++; $display("FAIL mrst_pre_pc: got %h want 400", pc); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL mrst_pre_full: got %0b want 0", full); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mrst_req: got %0b want 0", imem_req); end
    n_cmp++; if (imem_addr !== '0) begin n_err++; $display("FAIL mrst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (ce !== 1'b0) begin n_err++; $display("FAIL mrst_ce: got %0b want 0", ce); end
    n_cmp++; if (instr !== '0) begin n_err++; $display("FAIL mrst_instr: got %h want 0", instr); end
    n_cmp++; if (pc !== '0) begin n_err++; $display("FAIL mrst_pc: got %h want 0", pc); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mrst_empty: got %0b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL mrst_full: got %0b want 0", full); end
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mrst_c0_req: got %0b want 0", imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL mrst_c1_req: got %0b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL mrst_c1_addr: got %h want 0", imem_addr); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mrst_c1_empty: got %0b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_deq_one();
    test_back_to_back_stream();
    test_redirect();
    test_back_to_back_redirect();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_redirect_queue.md
FETCH_REDIRECT_QUEUE -- requirements
Module: fetch_redirect_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of instruction-queue entries; power of two, minimum 2.
REQ-002 Parameter: RESET_PC, default 0, first fetch address after reset.
REQ-003 Port: fq_i_clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port: fq_i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: fq_o_imem_req, output, 1, instruction-memory read request.
REQ-006 Port: fq_o_imem_addr, output, `PC_WIDTH, byte address of the request.
REQ-007 Port: fq_i_imem_valid, input, 1, read data valid; fixed latency of 1 cycle after the request.
REQ-008 Port: fq_i_imem_instr, input, 32, instruction word.
REQ-009 Port: fq_i_change_pc, input, 1, redirect from the execute stage.
REQ-010 Port: fq_i_alu_pc, input, `PC_WIDTH, redirect target; sampled only when fq_i_change_pc=1.
REQ-011 Port: fq_i_deq, input, 1, decode consumes the head entry.
REQ-012 Port: fq_o_ce, output, 1, head entry valid.
REQ-013 Port: fq_o_instr, output, 32, head instruction.
REQ-014 Port: fq_o_pc, output, `PC_WIDTH, head instruction address.
REQ-015 Port: fq_o_full, output, 1, count equals DEPTH.
REQ-016 Port: fq_o_empty, output, 1, count equals 0.

Function
REQ-017 States SHALL be: RESET_WAIT, FETCH, HOLD and REDIRECT, with RESET_WAIT entered on reset.
- RESET_WAIT -> FETCH after 1 cycle.
- FETCH -> HOLD when no credit is available.
- HOLD -> FETCH when credit returns.
- Any state -> REDIRECT on fq_i_change_pc.
- REDIRECT -> FETCH next cycle.
REQ-018 Credit SHALL be defined as (count + in-flight) < DEPTH; in-flight is at most 1.
REQ-019 In FETCH with credit, fq_o_imem_req=1 and fq_o_imem_addr=fetch_pc; fetch_pc advances by 4 on each issued request, wrapping modulo 2^`PC_WIDTH.
REQ-020 Each fq_i_imem_valid SHALL push {instr, address of the matching request} at the tail.
REQ-021 The head SHALL be driven combinationally from queue storage.
REQ-022 fq_i_deq with fq_o_ce=0 SHALL be ignored.
REQ-023 Simultaneous push and deq SHALL leave the count unchanged.
REQ-024 The queue SHALL never overflow; the credit rule guarantees this.
REQ-025 fq_i_change_pc=1 in cycle N SHALL, in that cycle:
- clear the queue;
- discard any fq_i_imem_valid arriving in cycle N;
- force fq_o_imem_req=0;
- load fetch_pc<=fq_i_alu_pc.
REQ-026 The first request at the redirect target SHALL issue in cycle N+1; its instruction SHALL appear at fq_o_ce in N+2 (N+3 without bypass, see REQ-031).
REQ-027 A redirect arriving while in REDIRECT SHALL restart REDIRECT with the newer target.
REQ-028 fq_i_change_pc SHALL take priority over fq_i_deq and push in the same cycle.

Reset
REQ-029 While fq_i_rst_n=0, the block SHALL hold:
- fq_o_imem_req=0, fq_o_imem_addr=0;
- fq_o_ce=0, fq_o_instr=0, fq_o_pc=0;
- fq_o_empty=1, fq_o_full=0;
- count=0, in-flight=0, fetch_pc=RESET_PC, state=RESET_WAIT.
REQ-030 Reset asserted mid-operation SHALL discard all entries and in-flight responses; a response arriving in the first cycle after release SHALL be ignored.

Configuration
REQ-031 Macro FQ_BYPASS_EN:
- Defined: when the queue is empty and fq_i_imem_valid=1 with no redirect, the response SHALL appear at fq_o_ce/fq_o_instr/fq_o_pc in the same cycle. If fq_i_deq=1 that cycle, it SHALL be consumed without being stored.
- Undefined: the response SHALL appear one cycle after fq_i_imem_valid.

Verification
REQ-032 Reset release with RESET_PC=0, memory always responding, fq_i_deq=0 -> requests at 0x0, 0x4, 0x8, 0xC. fq_o_full=1 after the 4th response. No 5th request while full.
REQ-033 Full queue, fq_i_deq=1 for one cycle -> head pc advances 0x0->0x4. Exactly one new request issues, at 0x10.
REQ-034 fq_i_change_pc=1, fq_i_alu_pc=0x100 in cycle N while a response is arriving -> response dropped, fq_o_empty=1 in N+1, request 0x100 in N+1, fq_o_pc=0x100 in N+2 (bypass) or N+3 (no bypass).
REQ-035 Back-to-back redirects to 0x200 then 0x300 -> no request or entry at 0x200. First fetch at 0x300.
REQ-036 fq_i_rst_n pulsed low for 1 cycle mid-stream with 3 entries -> all outputs at their reset values. Fetch restarts at RESET_PC two cycles after release.
REQ-037 fetch_pc=0xFFFFFFFC with `PC_WIDTH=32 -> next request address 0x00000000.
